// File: rtl/uart_boot_pkg.sv
// uart_boot_pkg: shared definitions for the UART boot loader.
// Holds the frame sequencer state encodings and the default frame start byte.
// No ports; imported by uart_boot_loader.
package uart_boot_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CKSUM = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } boot_state_t;

  localparam logic [7:0] DEFAULT_HDR_BYTE = 8'hA5;

endpackage

// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if: bundles the byte stream from uart_rx, the IMEM write
// port and the core-control/status lines of the boot loader.
//   rx_data/rx_valid              received byte and its 1-cycle strobe
//   imem_we/imem_addr/imem_wdata  IMEM word write port
//   cpu_rst_n                     core reset, active-low
//   busy/load_done/load_err       frame status
// Modports: master = boot loader side, slave = environment (uart_rx, IMEM, core).
interface uart_boot_loader_if #(
  parameter int ADDR_W = 8
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              load_done;
  logic              load_err;

  modport master (
    input  rx_data, rx_valid,
    output imem_we, imem_addr, imem_wdata, cpu_rst_n, busy, load_done, load_err
  );

  modport slave (
    output rx_data, rx_valid,
    input  imem_we, imem_addr, imem_wdata, cpu_rst_n, busy, load_done, load_err
  );

endinterface

// File: rtl/uart_boot_loader_gap_timer.sv
// boot_gap_timer: counts cycles since the last received byte while a frame is open.
//   sys_clk    in  system clock
//   sys_rst_n  in  synchronous active-low reset
//   enable     in  1 while the frame sequencer waits for frame bytes
//   clear      in  byte received this cycle; restarts the count
//   expire     out 1 once TIMEOUT_CLKS idle cycles have elapsed (until cleared/disabled)
module boot_gap_timer #(
  parameter int TIMEOUT_CLKS = 104160
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);

  logic [CNT_W-1:0] count;

  // The count saturates at the limit so a stalled FSM cannot wrap it back to 0.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || !enable || clear) begin
      count <= '0;
    end else if (count != CNT_W'(TIMEOUT_CLKS)) begin
      count <= count + CNT_W'(1);
    end
  end

  // A byte arriving in the expiry cycle wins over the timeout.
  assign expire = enable && !clear && (count == CNT_W'(TIMEOUT_CLKS));

endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: parses boot frames (HDR, LEN, 4*LEN data bytes LSB first,
// optional checksum) from uart_rx and writes the assembled 32-bit words to IMEM
// from address 0 upward, holding the core in reset while a load is in progress.
//   sys_clk    in  system clock
//   sys_rst_n  in  synchronous active-low reset
//   bus        master modport of uart_boot_loader_if (rx stream, IMEM write, status)
// Build option: define BOOT_CKSUM_EN to require a trailing XOR checksum byte
// covering LEN and all data bytes.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int         ADDR_W       = 8,
  parameter logic [7:0] HDR_BYTE     = DEFAULT_HDR_BYTE,
  parameter int         TIMEOUT_CLKS = 104160
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  uart_boot_loader_if.master  bus
);

  // One extra bit so a full-depth load (N = 2**ADDR_W) does not wrap.
  localparam int WCNT_W = ADDR_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;

  boot_state_t       state, state_n;
  logic              cpu_rst_n_q, cpu_rst_n_n;
  logic              we_q, we_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [31:0]       wdata_q, wdata_n;
  logic [23:0]       word_buf, word_buf_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [WCNT_W-1:0] word_cnt, word_cnt_n;
  logic [WCNT_W-1:0] len_q, len_n;
  logic              timer_en;
  logic              expire;
`ifdef BOOT_CKSUM_EN
  logic [7:0]        xor_q, xor_n;
`endif

  assign timer_en = (state == LEN) || (state == DATA) || (state == CKSUM);

  boot_gap_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_gap_timer (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .enable   (timer_en),
    .clear    (bus.rx_valid),
    .expire   (expire)
  );

  // State and datapath registers; reset leaves the core running its preloaded image.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      cpu_rst_n_q <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      word_buf    <= '0;
      byte_cnt    <= '0;
      word_cnt    <= '0;
      len_q       <= '0;
`ifdef BOOT_CKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      state       <= state_n;
      cpu_rst_n_q <= cpu_rst_n_n;
      we_q        <= we_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      word_buf    <= word_buf_n;
      byte_cnt    <= byte_cnt_n;
      word_cnt    <= word_cnt_n;
      len_q       <= len_n;
`ifdef BOOT_CKSUM_EN
      xor_q       <= xor_n;
`endif
    end
  end

  // Frame sequencing. The IMEM write is registered, so the write pulse appears
  // the cycle after the 4th byte of a word. A received byte takes priority over a timeout.
  always_comb begin
    state_n     = state;
    cpu_rst_n_n = cpu_rst_n_q;
    we_n        = 1'b0;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    word_buf_n  = word_buf;
    byte_cnt_n  = byte_cnt;
    word_cnt_n  = word_cnt;
    len_n       = len_q;
`ifdef BOOT_CKSUM_EN
    xor_n       = xor_q;
`endif
    case (state)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == HDR_BYTE) begin
          state_n     = LEN;
          cpu_rst_n_n = 1'b0;
        end
      end
      LEN: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'd0 || int'(bus.rx_data) > DEPTH) begin
            state_n = ERR;
          end else begin
            len_n      = WCNT_W'(bus.rx_data);
            word_cnt_n = '0;
            byte_cnt_n = '0;
`ifdef BOOT_CKSUM_EN
            xor_n      = bus.rx_data;
`endif
            state_n    = DATA;
          end
        end else if (expire) begin
          state_n = ERR;
        end
      end
      DATA: begin
        if (bus.rx_valid) begin
`ifdef BOOT_CKSUM_EN
          xor_n = xor_q ^ bus.rx_data;
`endif
          case (byte_cnt)
            2'd0: word_buf_n[7:0]   = bus.rx_data;
            2'd1: word_buf_n[15:8]  = bus.rx_data;
            2'd2: word_buf_n[23:16] = bus.rx_data;
            default: begin
              we_n       = 1'b1;
              addr_n     = word_cnt[ADDR_W-1:0];
              wdata_n    = {bus.rx_data, word_buf};
              word_cnt_n = word_cnt + WCNT_W'(1);
              if (word_cnt_n == len_q) begin
`ifdef BOOT_CKSUM_EN
                state_n = CKSUM;
`else
                state_n = DONE;
`endif
              end
            end
          endcase
          byte_cnt_n = byte_cnt + 2'd1;
        end else if (expire) begin
          state_n = ERR;
        end
      end
      CKSUM: begin
`ifdef BOOT_CKSUM_EN
        if (bus.rx_valid) begin
          state_n = (bus.rx_data == xor_q) ? DONE : ERR;
        end else if (expire) begin
          state_n = ERR;
        end
`else
        state_n = ERR;
`endif
      end
      DONE: begin
        cpu_rst_n_n = 1'b1;
        state_n     = IDLE;
      end
      ERR: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_rst_n  = cpu_rst_n_q;
  assign bus.busy       = (state != IDLE);
  assign bus.load_done  = (state == DONE);
  assign bus.load_err   = (state == ERR);

endmodule
